// File: rtl/fibonacci_checker_if.sv
// Stream and status bundle for the Fibonacci stream checker.
// The master drives the stream, the slave (the checker) returns status.
interface fibonacci_checker_if #(
    parameter int WIDTH = 16
);
    logic             valid;
    logic [WIDTH-1:0] value;
    logic             locked;
    logic             match;
    logic             error;
    logic             seq_done;
    logic [4:0]       index;
    logic [7:0]       error_count;
    logic [15:0]      seq_count;

    modport master (
        output valid, value,
        input  locked, match, error, seq_done, index, error_count, seq_count
    );

    modport slave (
        input  valid, value,
        output locked, match, error, seq_done, index, error_count, seq_count
    );
endinterface

// File: rtl/fibonacci_checker.sv
// Fibonacci stream checker: aligns on a 0 delimiter, then expects
// F(1)..F(TERMS) followed by another 0, and reports matches and errors.
//
// state | meaning
// HUNT  | unlocked, waiting for a 0 to align on
// TRACK | locked, expecting the next term (held in b)
// WRAP  | locked, full sequence seen, expecting the 0 delimiter
module fibonacci_checker #(
    parameter int WIDTH = 16,
    parameter int TERMS = 24
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    fibonacci_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        WRAP  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_INDEX = 5'(TERMS);

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // Sequence tracking FSM with registered status outputs and counters.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state            <= HUNT;
            a                <= '0;
            b                <= WIDTH'(1);
            bus.locked       <= 1'b0;
            bus.match        <= 1'b0;
            bus.error        <= 1'b0;
            bus.seq_done     <= 1'b0;
            bus.index        <= '0;
            bus.error_count  <= '0;
            bus.seq_count    <= '0;
        end else begin
            bus.match    <= 1'b0;
            bus.error    <= 1'b0;
            bus.seq_done <= 1'b0;
            if (bus.valid) begin
                unique case (state)
                    HUNT: begin
                        if (bus.value == '0) begin
                            state      <= TRACK;
                            a          <= '0;
                            b          <= WIDTH'(1);
                            bus.index  <= '0;
                            bus.locked <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (bus.value == b) begin
                            bus.match <= 1'b1;
                            a         <= b;
                            // Sum wraps at WIDTH bits; the carry is never needed.
                            b         <= a + b;
                            bus.index <= bus.index + 5'd1;
                            if (bus.index + 5'd1 == LAST_INDEX) begin
                                bus.seq_done  <= 1'b1;
                                bus.seq_count <= bus.seq_count + 16'd1;
                                state         <= WRAP;
                            end
                        end else begin
                            bus.error <= 1'b1;
                            if (bus.error_count != 8'hFF)
                                bus.error_count <= bus.error_count + 8'd1;
                            bus.index <= '0;
                            if (bus.value == '0) begin
                                // A stray 0 is itself a valid delimiter: realign at once.
                                a <= '0;
                                b <= WIDTH'(1);
                            end else begin
                                state      <= HUNT;
                                bus.locked <= 1'b0;
                            end
                        end
                    end
                    WRAP: begin
                        bus.index <= '0;
                        if (bus.value == '0) begin
                            state <= TRACK;
                            a     <= '0;
                            b     <= WIDTH'(1);
                        end else begin
                            bus.error <= 1'b1;
                            if (bus.error_count != 8'hFF)
                                bus.error_count <= bus.error_count + 8'd1;
                            state      <= HUNT;
                            bus.locked <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= HUNT;
                        bus.locked <= 1'b0;
                        bus.index  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed testbench for fibonacci_checker.
module tb_fibonacci_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   fib [0:24];
    int   match_total;

    fibonacci_checker_if #(.WIDTH(16)) bus ();

    fibonacci_checker #(.WIDTH(16), .TERMS(24)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one input for one clock, then sample the registered result.
    task automatic step(input logic v, input logic [15:0] val);
        bus.valid = v;
        bus.value = val;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    // Feed F(first)..F(last) expecting every term to match.
    task automatic feed_terms(input int first, input int last, input string tag);
        for (int k = first; k <= last; k++) begin
            step(1'b1, 16'(fib[k]));
            check({tag, "_match"}, 32'(bus.match), 32'd1);
            check({tag, "_error"}, 32'(bus.error), 32'd0);
            check({tag, "_index"}, 32'(bus.index), 32'(k));
        end
    endtask

    initial begin
        fib[0] = 0;
        fib[1] = 1;
        for (int k = 2; k <= 24; k++) fib[k] = fib[k-1] + fib[k-2];

        bus.valid = 1'b0;
        bus.value = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_match", 32'(bus.match), 32'd0);
        check("rst_index", 32'(bus.index), 32'd0);
        check("rst_errcnt", 32'(bus.error_count), 32'd0);
        check("rst_seqcnt", 32'(bus.seq_count), 32'd0);

        // Nonzero values while hunting are ignored.
        step(1'b1, 16'd7);
        check("hunt_ignore_err", 32'(bus.error), 32'd0);
        check("hunt_ignore_lock", 32'(bus.locked), 32'd0);

        // Contiguous full sequence.
        step(1'b1, 16'd0);
        check("lock_locked", 32'(bus.locked), 32'd1);
        check("lock_match", 32'(bus.match), 32'd0);
        check("lock_index", 32'(bus.index), 32'd0);
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 16'(fib[k]));
            check("seq_match", 32'(bus.match), 32'd1);
            check("seq_index", 32'(bus.index), 32'(k));
            check("seq_done", 32'(bus.seq_done), (k == 24) ? 32'd1 : 32'd0);
            check("seq_error", 32'(bus.error), 32'd0);
        end
        check("seq_last_value", 32'(fib[24]), 32'd46368);
        check("seq_count1", 32'(bus.seq_count), 32'd1);
        step(1'b1, 16'd0);
        check("wrap_locked", 32'(bus.locked), 32'd1);
        check("wrap_match", 32'(bus.match), 32'd0);
        check("wrap_index", 32'(bus.index), 32'd0);
        check("wrap_seqcnt", 32'(bus.seq_count), 32'd1);
        check("wrap_errcnt", 32'(bus.error_count), 32'd0);

        // Same sequence with idle gaps; outputs must hold during gaps.
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 16'(fib[k]));
            check("gap_match", 32'(bus.match), 32'd1);
            check("gap_done", 32'(bus.seq_done), (k == 24) ? 32'd1 : 32'd0);
            for (int g = 0; g < (k % 3) + 1; g++) begin
                step(1'b0, 16'hFFFF);
                check("idle_match", 32'(bus.match), 32'd0);
                check("idle_done", 32'(bus.seq_done), 32'd0);
                check("idle_error", 32'(bus.error), 32'd0);
                check("idle_index", 32'(bus.index), 32'(k));
                check("idle_locked", 32'(bus.locked), 32'd1);
            end
        end
        step(1'b1, 16'd0);
        check("gap_seqcnt", 32'(bus.seq_count), 32'd2);
        check("gap_index", 32'(bus.index), 32'd0);
        check("gap_errcnt", 32'(bus.error_count), 32'd0);

        // Wrong term drops lock; following values ignored; 0 relocks.
        feed_terms(1, 7, "pre_bad");
        step(1'b1, 16'd22);
        check("bad_error", 32'(bus.error), 32'd1);
        check("bad_match", 32'(bus.match), 32'd0);
        check("bad_locked", 32'(bus.locked), 32'd0);
        check("bad_errcnt", 32'(bus.error_count), 32'd1);
        check("bad_index", 32'(bus.index), 32'd0);
        step(1'b1, 16'd34);
        check("ign34_error", 32'(bus.error), 32'd0);
        check("ign34_locked", 32'(bus.locked), 32'd0);
        step(1'b1, 16'd55);
        check("ign55_error", 32'(bus.error), 32'd0);
        check("ign55_errcnt", 32'(bus.error_count), 32'd1);
        step(1'b1, 16'd0);
        check("relock_locked", 32'(bus.locked), 32'd1);
        check("relock_error", 32'(bus.error), 32'd0);

        // Stray 0 mid-sequence: error but stays locked and realigns.
        feed_terms(1, 2, "pre_zero");
        step(1'b1, 16'd0);
        check("zero_error", 32'(bus.error), 32'd1);
        check("zero_match", 32'(bus.match), 32'd0);
        check("zero_locked", 32'(bus.locked), 32'd1);
        check("zero_index", 32'(bus.index), 32'd0);
        check("zero_errcnt", 32'(bus.error_count), 32'd2);
        feed_terms(1, 3, "post_zero");

        // Reset mid-sequence aborts quietly and clears counters.
        rst = 1'b1;
        step(1'b0, 16'd0);
        rst = 1'b0;
        step(1'b1, 16'd0);
        feed_terms(1, 10, "pre_rst");
        rst = 1'b1;
        step(1'b1, 16'(fib[11]));
        rst = 1'b0;
        check("rst_mid_locked", 32'(bus.locked), 32'd0);
        check("rst_mid_match", 32'(bus.match), 32'd0);
        check("rst_mid_error", 32'(bus.error), 32'd0);
        check("rst_mid_done", 32'(bus.seq_done), 32'd0);
        check("rst_mid_index", 32'(bus.index), 32'd0);
        check("rst_mid_errcnt", 32'(bus.error_count), 32'd0);
        check("rst_mid_seqcnt", 32'(bus.seq_count), 32'd0);
        step(1'b1, 16'(fib[12]));
        check("resume_error", 32'(bus.error), 32'd0);
        check("resume_locked", 32'(bus.locked), 32'd0);
        check("resume_match", 32'(bus.match), 32'd0);
        step(1'b1, 16'(fib[13]));
        check("resume2_errcnt", 32'(bus.error_count), 32'd0);
        step(1'b1, 16'd0);
        check("resume_relock", 32'(bus.locked), 32'd1);

        // Error counter saturation.
        match_total = 0;
        for (int r = 0; r < 300; r++) begin
            step(1'b1, 16'd0);
            match_total += int'(bus.match);
            step(1'b1, 16'd5);
            match_total += int'(bus.match);
        end
        check("sat_errcnt", 32'(bus.error_count), 32'd255);
        check("sat_matches", 32'(match_total), 32'd0);
        check("sat_seqcnt", 32'(bus.seq_count), 32'd0);
        check("sat_locked", 32'(bus.locked), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
